// File: rtl/gcd_job_driver.sv
// Initiator for a start/done GCD core: takes operand pairs on a valid/ready input, runs one job
// at a time with zero-operand bypass and a bounded wait, and returns the result on valid/ready.
module gcd_job_driver #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_x_i,
  input  logic [WIDTH-1:0] in_y_i,
  output logic             core_start_o,
  output logic [WIDTH-1:0] core_x_o,
  output logic [WIDTH-1:0] core_y_o,
  input  logic [WIDTH-1:0] core_gcd_i,
  input  logic             core_done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_gcd_o,
  output logic [WIDTH-1:0] out_x_o,
  output logic [WIDTH-1:0] out_y_o,
  output logic             out_timeout_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_x_q, op_x_d;
  logic [WIDTH-1:0]  op_y_q, op_y_d;
  logic [WIDTH-1:0]  gcd_q, gcd_d;
  logic              timeout_q, timeout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_x_q    <= '0;
      op_y_q    <= '0;
      gcd_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_x_q    <= op_x_d;
      op_y_q    <= op_y_d;
      gcd_q     <= gcd_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    gcd_d     = gcd_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          op_x_d    = in_x_i;
          op_y_d    = in_y_i;
          gcd_d     = '0;
          timeout_d = 1'b0;
          // gcd(a,0)=a and gcd(0,0)=0, so the OR is the answer without the core
          if (in_x_i == '0 || in_y_i == '0) begin
            gcd_d   = in_x_i | in_y_i;
            state_d = StHold;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (core_done_i) begin
          gcd_d     = core_gcd_i;
          timeout_d = 1'b0;
          state_d   = StHold;
        end else if (cnt_q == CntMax) begin
          gcd_d     = '0;
          timeout_d = 1'b1;
          state_d   = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded from state only, so the async reset drops core_start immediately
  assign in_ready_o    = (state_q == StIdle);
  assign core_start_o  = (state_q == StStart);
  assign out_valid_o   = (state_q == StHold);
  assign busy_o        = (state_q != StIdle);
  assign core_x_o      = op_x_q;
  assign core_y_o      = op_y_q;
  assign out_x_o       = op_x_q;
  assign out_y_o       = op_y_q;
  assign out_gcd_o     = gcd_q;
  assign out_timeout_o = timeout_q;

endmodule

// File: tb/tb_gcd_job_driver.sv
// Bench for gcd_job_driver: directed vector table, corner sequences, and random jobs checked
// against a Euclid reference and a simple latency model.
module tb_gcd_job_driver;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_x_i = '0;
  logic [WIDTH-1:0] in_y_i = '0;
  logic             core_start_o;
  logic [WIDTH-1:0] core_x_o, core_y_o;
  logic [WIDTH-1:0] core_gcd_i;
  logic             core_done_i;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [WIDTH-1:0] out_gcd_o, out_x_o, out_y_o;
  logic             out_timeout_o;
  logic             busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int core_delay = 0;  // cycles from start to done; 0 means the core never answers

  gcd_job_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_x_i(in_x_i), .in_y_i(in_y_i),
    .core_start_o(core_start_o), .core_x_o(core_x_o), .core_y_o(core_y_o),
    .core_gcd_i(core_gcd_i), .core_done_i(core_done_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_gcd_o(out_gcd_o),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_timeout_o(out_timeout_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Core model: single done pulse core_delay cycles after the start cycle
  logic             pend;
  int               dcnt;
  logic [WIDTH-1:0] res;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend        <= 1'b0;
      dcnt        <= 0;
      core_done_i <= 1'b0;
      res         <= '0;
    end else begin
      core_done_i <= 1'b0;
      if (core_start_o) begin
        pend <= (core_delay >= 2);
        dcnt <= 1;
        res  <= ref_gcd(core_x_o, core_y_o);
      end else if (pend) begin
        dcnt <= dcnt + 1;
        if (dcnt + 1 == core_delay) begin
          core_done_i <= 1'b1;
          pend        <= 1'b0;
        end
      end
    end
  end
  assign core_gcd_i = res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input int d, input logic [WIDTH-1:0] eg, input logic eto,
                         input int elat, input int estarts, input int hold);
    int starts, sidx, lat;
    core_delay = d;
    @(negedge clk_i);
    check({name, "_in_ready"}, 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1;
    in_x_i     = x;
    in_y_i     = y;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    starts = 0;
    sidx   = -1;
    lat    = -1;
    for (int i = 1; i <= 40; i++) begin
      if (core_start_o) begin
        starts++;
        if (sidx < 0) sidx = i;
      end
      if (out_valid_o) begin
        lat = i;
        break;
      end
      @(negedge clk_i);
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_starts"}, 64'(starts), 64'(estarts));
    if (estarts > 0) check({name, "_start_cycle"}, 64'(sidx), 64'd1);
    check({name, "_gcd"}, 64'(out_gcd_o), 64'(eg));
    check({name, "_timeout"}, 64'(out_timeout_o), 64'(eto));
    check({name, "_x"}, 64'(out_x_o), 64'(x));
    check({name, "_y"}, 64'(out_y_o), 64'(y));
    for (int k = 0; k < hold; k++) begin
      in_valid_i = 1'b1;
      in_x_i     = 99;
      in_y_i     = 77;
      @(negedge clk_i);
      check({name, "_hold_in_ready"}, 64'(in_ready_o), 64'd0);
      check({name, "_hold_valid"}, 64'(out_valid_o), 64'd1);
      check({name, "_hold_gcd"}, 64'(out_gcd_o), 64'(eg));
      check({name, "_hold_x"}, 64'(out_x_o), 64'(x));
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check({name, "_consumed_valid"}, 64'(out_valid_o), 64'd0);
    check({name, "_consumed_busy"}, 64'(busy_o), 64'd0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    int               d;
    logic [WIDTH-1:0] g;
    logic             to;
    int               lat;
    int               starts;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{x: 15, y: 10, d: 6,  g: 5,  to: 0, lat: 8,  starts: 1};
    vecs[1] = '{x: 0,  y: 42, d: 0,  g: 42, to: 0, lat: 1,  starts: 0};
    vecs[2] = '{x: 0,  y: 0,  d: 0,  g: 0,  to: 0, lat: 1,  starts: 0};
    vecs[3] = '{x: 7,  y: 0,  d: 5,  g: 7,  to: 0, lat: 1,  starts: 0};
    vecs[4] = '{x: 9,  y: 6,  d: 0,  g: 0,  to: 1, lat: 18, starts: 1};
    vecs[5] = '{x: 9,  y: 6,  d: 16, g: 3,  to: 0, lat: 18, starts: 1};
    vecs[6] = '{x: 9,  y: 6,  d: 17, g: 0,  to: 1, lat: 18, starts: 1};
    vecs[7] = '{x: 9,  y: 6,  d: 2,  g: 3,  to: 0, lat: 4,  starts: 1};
    vecs[8] = '{x: 35, y: 49, d: 3,  g: 7,  to: 0, lat: 5,  starts: 1};

    // T1 reset
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_core_start", 64'(core_start_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_out_gcd", 64'(out_gcd_o), 64'd0);

    foreach (vecs[i])
      run_job($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].g, vecs[i].to,
              vecs[i].lat, vecs[i].starts, 1);

    // T5 long backpressure, competing offers refused, then next job accepted
    run_job("bp", 48, 36, 3, 12, 1'b0, 5, 1, 10);
    run_job("bp_next", 20, 8, 4, 4, 1'b0, 6, 1, 0);

    // T6a reset during START drops core_start asynchronously
    core_delay = 0;
    @(negedge clk_i);
    in_valid_i = 1'b1; in_x_i = 21; in_y_i = 14;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("rst_start_pre", 64'(core_start_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_start_core_start", 64'(core_start_o), 64'd0);
    check("rst_start_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // T6b reset mid-WAIT drops the job
    @(negedge clk_i);
    in_valid_i = 1'b1; in_x_i = 21; in_y_i = 14;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("rst_wait_busy_pre", 64'(busy_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_wait_busy", 64'(busy_o), 64'd0);
    check("rst_wait_out_x", 64'(out_x_o), 64'd0);
    check("rst_wait_core_x", 64'(core_x_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_wait_no_result", 64'(out_valid_o), 64'd0);
    run_job("resubmit", 21, 14, 4, 7, 1'b0, 6, 1, 0);

    // Random jobs against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] x, y, eg;
      logic eto;
      int d, elat, est, f;
      f = $urandom_range(1, 20);
      x = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 500) * f);
      y = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 500) * f);
      if ($urandom_range(0, 5) == 0) x = $urandom;
      d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, 20);
      if (x == 0 || y == 0) begin
        eg = x | y; eto = 1'b0; elat = 1; est = 0;
      end else if (d >= 2 && d <= TIMEOUT) begin
        eg = ref_gcd(x, y); eto = 1'b0; elat = d + 2; est = 1;
      end else begin
        eg = '0; eto = 1'b1; elat = TIMEOUT + 2; est = 1;
      end
      run_job($sformatf("rnd%0d", n), x, y, d, eg, eto, elat, est, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
